boot_loader_ctrl: RTL and testbench
===================================

# boot_loader_ctrl

Boot-time controller that owns the instruction memory write port and the core's reset. It accepts a framed byte stream (length, payload, checksum) and assembles little-endian 32-bit words. Each word is written into instruction memory at consecutive word addresses, and `riscv` is held in reset until a complete, checksum-valid image is loaded. It sits between the SoC byte source (UART receiver or debug shim) and the `riscv` / `inst_mem` pair inside `soc_top`, replacing testbench `$readmemh` preload on hardware.

## Interface
Parameters:
- `MEM_DEPTH`, 256: instruction memory depth in 32-bit words; equals `INST_MEM_ADDR_DEPTH`.
- `ADDR_W`, 8: word address width; `2**ADDR_W >= MEM_DEPTH`.
- `TIMEOUT_CYC`, 100000: maximum idle cycles between accepted bytes inside a frame.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `boot_start`  in  1  one-cycle pulse that starts a load.
- `rx_valid`  in  1  byte available.
- `rx_data`  in  8  byte value.
- `rx_ready`  out  1  byte accepted when `rx_valid && rx_ready`.
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  write word (`CPU_WIDTH`).
- `core_rst_n`  out  1  reset to `riscv`; low means held in reset.
- `busy`  out  1  frame in progress.
- `done`  out  1  last load succeeded.
- `err`  out  1  last load failed.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4·N payload bytes, then one checksum byte.
- The checksum is the 8-bit sum modulo 256 of payload bytes only; header bytes are excluded.
- Payload byte k of word w maps to `mem_wdata[8k+7:8k]`, which gives the same word layout as `$readmemh` on `text.hex`.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR. After reset the FSM is in IDLE.
- IDLE/DONE/ERR + `boot_start` → LEN_LO. On entry to LEN_LO:
  - `core_rst_n` is driven to 0;
  - `done`, `err`, word index, byte index and checksum accumulator are cleared.
- `boot_start` is ignored in LEN_LO, LEN_HI, DATA and CSUM.
- LEN_LO → LEN_HI on the accepted byte.
- LEN_HI on the accepted byte:
  - if N > MEM_DEPTH → ERR;
  - if N == 0 → CSUM;
  - otherwise → DATA.
- DATA: each accepted byte is added to the checksum and shifted into the word buffer.
  - On byte index 3, the word is written (see Timing) and the word index increments.
  - After word N−1 is written, the FSM goes to CSUM.
- CSUM on the accepted byte:
  - equal to the accumulator → DONE;
  - otherwise → ERR.
- DONE: `done`=1 and `core_rst_n`=1.
- ERR: `err`=1 and `core_rst_n` stays 0. Words already written are left in memory.
- Timeout: in LEN_HI, DATA or CSUM, a counter increments each cycle with no accepted byte and clears on every accepted byte. When it reaches TIMEOUT_CYC the FSM goes to ERR.
- `rx_ready` = 1 exactly in LEN_LO, LEN_HI, DATA and CSUM.
- `busy` = 1 in the same states.

## Timing
- Reset values (asynchronous):
  - `core_rst_n`, `rx_ready`, `mem_we`, `busy`, `done` and `err` = 0;
  - `mem_addr` and `mem_wdata` = 0;
  - state = IDLE.
- Asserting `rst_n` mid-frame aborts immediately; no partial write is issued.
- `boot_start` at edge t: state is LEN_LO from t+1, so `rx_ready`=1 and `busy`=1 from t+1.
- 4th byte of word w accepted at edge t: during cycle t+1, `mem_we`=1 with `mem_addr`=w and full `mem_wdata`. The strobe lasts one cycle.
- `rx_ready` stays 1 while a write is pending, so back-to-back bytes at one byte per cycle never stall.
- Checksum byte accepted at edge t: `done`/`err` and `core_rst_n` take their new values at t+1, and `busy`=0 from t+1.
- Oversize length detected at the LEN_HI byte edge t: `err`=1 from t+1, and `mem_we` is never asserted.
- Timeout: if the last byte was accepted at edge t and none follows, `err`=1 at t+TIMEOUT_CYC+1.
- `mem_addr` counts 0..N−1 without wrap. N is capped by the MEM_DEPTH check, so the address never exceeds MEM_DEPTH−1.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0 and `core_rst_n`=0. Assert `rst_n` mid-DATA → outputs drop to 0 asynchronously and no `mem_we` pulse follows.
- Good frame:
  - Stimulus: `boot_start`, then bytes 02 00 13 00 00 00 93 00 10 00 B6 at one per cycle.
  - Writes: addr0=0x00000013 and addr1=0x00100093.
  - Result: `done`=1 and `core_rst_n`=1 one cycle after the B6 byte; `riscv` then fetches and executes.
- Bad checksum: same frame with B7 last → both words are written, `err`=1, `core_rst_n` stays 0, `done`=0.
- Oversize: LEN bytes 01 01 with MEM_DEPTH=256 → `err`=1 the cycle after LEN_HI, `rx_ready`=0, `mem_we` never 1.
- Gaps and timeout:
  - Random `rx_valid` gaps shorter than TIMEOUT_CYC (set to 20) inside the good frame → identical writes and `done`.
  - A stall after byte 5 → `err`=1 exactly 21 cycles after the last accepted byte.
- Empty and reload:
  - Frame 00 00 00 → `done`=1 with no writes.
  - A second `boot_start` from DONE → `core_rst_n` drops the next cycle and the good frame reloads correctly.
  - A `boot_start` pulsed during DATA is ignored.

Source files
------------

// File: rtl/boot_loader_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader_ctrl_if
// Description : Byte-stream handshake and instruction-memory write port.
// Revision    : 1.0
// ============================================================================
interface boot_loader_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : boot_loader_ctrl
// Description : Loads a framed, checksummed image into instruction memory and
//               holds the core in reset until the image is valid.
// Revision    : 1.0
// ============================================================================
module boot_loader_ctrl #(
    parameter int MEM_DEPTH   = 256,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_boot_start,
    boot_loader_ctrl_if.slave io_bus,
    output logic              o_core_rst_n,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);
    localparam int                 c_TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0]        c_MAX_LEN  = 17'(MEM_DEPTH);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_len;
    logic [15:0]        r_word_idx;
    logic [1:0]         r_byte_idx;
    logic [7:0]         r_csum;
    logic [23:0]        r_buf;
    logic [c_TMO_W-1:0] r_tmo;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_mem_wdata;

    logic               w_in_frame;
    logic               w_accept;
    logic               w_start;
    logic               w_tmo_hit;
    logic               w_last_word;
    logic [15:0]        w_len_full;

    assign w_in_frame  = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                         (r_state == S_DATA)   || (r_state == S_CSUM);
    assign w_accept    = io_bus.rx_valid && w_in_frame;
    assign w_start     = i_boot_start && !w_in_frame;
    // Fires on the cycle the idle counter would reach TIMEOUT_CYC.
    assign w_tmo_hit   = !w_accept && (r_tmo == c_TMO_LAST);
    assign w_len_full  = {io_bus.rx_data, r_len[7:0]};
    assign w_last_word = (r_byte_idx == 2'd3) && (r_word_idx == r_len - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_start) begin
                    w_next = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    w_next = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_accept) begin
                    if ({1'b0, w_len_full} > c_MAX_LEN) begin
                        w_next = S_ERR;
                    end else if (w_len_full == 16'd0) begin
                        w_next = S_CSUM;
                    end else begin
                        w_next = S_DATA;
                    end
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    if (w_last_word) begin
                        w_next = S_CSUM;
                    end
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_next = (io_bus.rx_data == r_csum) ? S_DONE : S_ERR;
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_csum      <= '0;
            r_buf       <= '0;
            r_tmo       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;

            if (w_start) begin
                r_word_idx <= '0;
                r_byte_idx <= '0;
                r_csum     <= '0;
            end

            if (w_accept) begin
                case (r_state)
                    S_LEN_LO: r_len[7:0]  <= io_bus.rx_data;
                    S_LEN_HI: r_len[15:8] <= io_bus.rx_data;
                    S_DATA: begin
                        r_csum     <= r_csum + io_bus.rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // Bytes arrive LSB first; the fourth completes the word.
                        case (r_byte_idx)
                            2'd0: r_buf[7:0]   <= io_bus.rx_data;
                            2'd1: r_buf[15:8]  <= io_bus.rx_data;
                            2'd2: r_buf[23:16] <= io_bus.rx_data;
                            default: begin
                                r_mem_we    <= 1'b1;
                                r_mem_addr  <= r_word_idx[ADDR_W-1:0];
                                r_mem_wdata <= {io_bus.rx_data, r_buf};
                                r_word_idx  <= r_word_idx + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end

            if ((r_state == S_LEN_HI) || (r_state == S_DATA) || (r_state == S_CSUM)) begin
                r_tmo <= w_accept ? '0 : r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end
        end
    end

    assign io_bus.rx_ready  = w_in_frame;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;

    assign o_busy       = w_in_frame;
    assign o_done       = (r_state == S_DONE);
    assign o_err        = (r_state == S_ERR);
    assign o_core_rst_n = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_boot_loader_ctrl
// Description : Self-checking bench for boot_loader_ctrl (frame-level model).
// Revision    : 1.0
// ============================================================================
module tb_boot_loader_ctrl;
    localparam int MEM_DEPTH   = 256;
    localparam int ADDR_W      = 8;
    localparam int TIMEOUT_CYC = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic boot_start = 1'b0;
    logic core_rst_n, busy, done, err;

    boot_loader_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    boot_loader_ctrl #(
        .MEM_DEPTH  (MEM_DEPTH),
        .ADDR_W     (ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_boot_start(boot_start),
        .io_bus      (bus),
        .o_core_rst_n(core_rst_n),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: tracks position in the byte stream, not controller states.
    logic        m_busy, m_done, m_err, m_we;
    logic [7:0]  m_sum;
    logic [7:0]  m_wb [4];
    logic [31:0] m_addr, m_wdata;
    int          m_pos, m_n, m_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_we = 0;
            m_pos = 0; m_n = 0; m_idle = 0; m_sum = 0;
        end else begin
            m_we = 0;
            if (!m_busy) begin
                if (boot_start) begin
                    m_busy = 1; m_done = 0; m_err = 0;
                    m_pos = 0; m_n = 0; m_idle = 0; m_sum = 0;
                end
            end else if (bus.rx_valid) begin
                m_idle = 0;
                if (m_pos == 0) begin
                    m_n = int'(bus.rx_data);
                end else if (m_pos == 1) begin
                    m_n = m_n + int'(bus.rx_data) * 256;
                    if (m_n > MEM_DEPTH) begin m_busy = 0; m_err = 1; end
                end else if (m_pos < 2 + 4 * m_n) begin
                    m_sum = m_sum + bus.rx_data;
                    m_wb[(m_pos - 2) % 4] = bus.rx_data;
                    if ((m_pos - 2) % 4 == 3) begin
                        m_we    = 1;
                        m_addr  = (m_pos - 2) / 4;
                        m_wdata = {m_wb[3], m_wb[2], m_wb[1], m_wb[0]};
                    end
                end else begin
                    m_busy = 0;
                    if (bus.rx_data == m_sum) m_done = 1; else m_err = 1;
                end
                m_pos++;
            end else if (m_pos > 0) begin
                m_idle++;
                if (m_idle >= TIMEOUT_CYC) begin m_busy = 0; m_err = 1; end
            end
        end
    end

    logic [31:0] tb_mem [0:MEM_DEPTH-1];
    int          we_count = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outs", {25'd0, core_rst_n, busy, done, err, bus.rx_ready, bus.mem_we, 1'b0}, 32'd0);
            chk("rst_addr", 32'(bus.mem_addr), 32'd0);
            chk("rst_wdata", bus.mem_wdata, 32'd0);
        end else begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("rx_ready", 32'(bus.rx_ready), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("err", 32'(err), 32'(m_err));
            chk("core_rst_n", 32'(core_rst_n), 32'(m_done));
            chk("mem_we", 32'(bus.mem_we), 32'(m_we));
            if (m_we) begin
                chk("mem_addr", 32'(bus.mem_addr), m_addr);
                chk("mem_wdata", bus.mem_wdata, m_wdata);
            end
            if (bus.mem_we) begin
                tb_mem[bus.mem_addr] = bus.mem_wdata;
                we_count++;
            end
        end
    end

    logic [7:0] good [11] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};

    task automatic pulse_start();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        boot_start   = 1'b1;
        @(negedge clk);
        boot_start   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] last, input int gap_max, input bit poke_start);
        for (int i = 0; i < 11; i++) begin
            send_byte((i == 10) ? last : good[i]);
            if (poke_start && i == 5) pulse_start();
            if (gap_max > 0) idle_cycles($urandom_range(gap_max, 0));
        end
        idle_cycles(2);
    endtask

    task automatic check_good(input string tag, input int we_before);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_nwrites"}, 32'(we_count - we_before), 32'd2);
        chk({tag, "_w0"}, tb_mem[0], 32'h0000_0013);
        chk({tag, "_w1"}, tb_mem[1], 32'h0010_0093);
    endtask

    initial begin
        int wc;
        int k;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        tb_mem[0] = '0;
        tb_mem[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Good frame, back to back.
        wc = we_count;
        pulse_start();
        chk("start_rx_ready", 32'(bus.rx_ready), 32'd1);
        send_frame(8'hB6, 0, 1'b0);
        check_good("good", wc);

        // Reload from DONE.
        tb_mem[0] = '0;
        tb_mem[1] = '0;
        wc = we_count;
        pulse_start();
        chk("reload_core_rst_drop", 32'(core_rst_n), 32'd0);
        chk("reload_done_clr", 32'(done), 32'd0);
        send_frame(8'hB6, 0, 1'b0);
        check_good("reload", wc);

        // Bad checksum.
        wc = we_count;
        pulse_start();
        send_frame(8'hB7, 0, 1'b0);
        chk("badcs_err", 32'(err), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        chk("badcs_core_rst_n", 32'(core_rst_n), 32'd0);
        chk("badcs_nwrites", 32'(we_count - wc), 32'd2);

        // Oversize length 257.
        wc = we_count;
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        chk("over_err", 32'(err), 32'd1);
        chk("over_rx_ready", 32'(bus.rx_ready), 32'd0);
        send_byte(8'h55);
        send_byte(8'h66);
        idle_cycles(2);
        chk("over_nwrites", 32'(we_count - wc), 32'd0);

        // Gapped frame with a stray boot_start mid-payload.
        tb_mem[0] = '0;
        tb_mem[1] = '0;
        wc = we_count;
        pulse_start();
        send_frame(8'hB6, TIMEOUT_CYC / 2, 1'b1);
        check_good("gaps", wc);

        // Timeout after five bytes.
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(good[i]);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            if (err && k == 0) k = i;
        end
        chk("timeout_cycles", 32'(k), 32'(TIMEOUT_CYC + 1));

        // Empty frame.
        wc = we_count;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        idle_cycles(2);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_nwrites", 32'(we_count - wc), 32'd0);

        // Reset mid-DATA, one byte short of a word.
        wc = we_count;
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(good[i]);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("async_mem_we", 32'(bus.mem_we), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(4);
        chk("abort_nwrites", 32'(we_count - wc), 32'd0);
        chk("abort_core_rst_n", 32'(core_rst_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
